// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-outstanding
// memory controller, with round-robin tie-breaking and a per-transaction timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [23:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_mode,
  input  logic [23:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_data_in,
  output logic        mem_enable,
  output logic [1:0]  mem_instr_mode,
  input  logic [31:0] mem_data_out,
  input  logic        mem_op_r
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner_d;  // 1 = data port owns the transaction in flight
  logic          last_d;   // 1 = data port was granted most recently
  logic          pick_d;

  // NOTE: the arbitration decision is a continuous assign, so it has a value
  // on every path and can never infer a latch.
  assign pick_d = d_req && (!if_req || !last_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      owner_d        <= 1'b0;
      last_d         <= 1'b0;
      if_ack         <= 1'b0;
      d_ack          <= 1'b0;
      err            <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_data_in    <= '0;
      mem_enable     <= 1'b0;
      mem_instr_mode <= 2'b00;
    end else begin
      // NOTE: state and outputs update with non-blocking assignments so every
      // branch below reads the values from before this clock edge.
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      mem_enable <= 1'b0;

      unique case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner_d        <= pick_d;
            mem_addr       <= pick_d ? d_addr : if_addr;
            mem_we         <= pick_d && d_we;
            mem_instr_mode <= pick_d ? d_mode : 2'b00;
            mem_data_in    <= pick_d ? d_wdata : '0;
            mem_enable     <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end

        WAIT: begin
          cnt <= cnt + CW'(1);
          // A ready pulse on the last allowed cycle still counts as success.
          if (mem_op_r || cnt == CW'(TIMEOUT - 1)) begin
            err <= !mem_op_r;
            if (owner_d) begin
              d_rdata <= (mem_op_r && !mem_we) ? mem_data_out : '0;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= (mem_op_r && !mem_we) ? mem_data_out : '0;
              if_ack   <= 1'b1;
            end
            state <= DONE;
          end
        end

        DONE: begin
          last_d         <= owner_d;
          mem_addr       <= '0;
          mem_we         <= 1'b0;
          mem_data_in    <= '0;
          mem_instr_mode <= 2'b00;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-addressed memory stub, transaction-level reference
// model compared every cycle, plus literal expectations for the key scenarios.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, d_req, d_we, d_ack, err;
  logic [23:0] if_addr, d_addr, mem_addr;
  logic [31:0] if_rdata, d_wdata, d_rdata, mem_data_in, mem_data_out;
  logic [1:0]  d_mode, mem_instr_mode;
  logic        mem_we, mem_enable, mem_op_r;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
    .mem_enable(mem_enable), .mem_instr_mode(mem_instr_mode),
    .mem_data_out(mem_data_out), .mem_op_r(mem_op_r)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] rdata;
    logic        err;
  } ack_t;
  ack_t        acks[$];
  int          en_cyc;
  logic [1:0]  en_mode;

  // [0] is the stub's memory, [1] the model's shadow copy
  bit [7:0] mem [2][256];

  // requester intentions
  bit          f_pend, f_gap, f_auto, f_cont;
  logic [23:0] f_a;
  bit          d_pend, d_gap, d_auto, d_cont;
  logic        d_w;
  logic [1:0]  d_m;
  logic [23:0] d_a;
  logic [31:0] d_wd;
  bit          rst_cmd;

  // memory stub: 0 = fixed 4-cycle controller, 1 = random latency, 2 = never answers
  int          stub_mode;
  bit          spur_en, stub_pend;
  int          stub_resp;
  logic [31:0] stub_rd;

  // reference model
  bit          m_busy, m_is_d, m_last_d, m_we, m_err;
  int          m_t0, m_done_cyc;
  logic [23:0] m_addr;
  logic [1:0]  m_mode;
  logic [31:0] m_wdata, exp_if, exp_d;

  function automatic logic [31:0] mread(int k, logic [23:0] a, logic [1:0] m);
    logic [31:0] v;
    int nb;
    v  = '0;
    nb = (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 4;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mem[k][8'(a + 24'(i))];
    return v;
  endfunction

  function automatic void mwrite(int k, logic [23:0] a, logic [1:0] m, logic [31:0] d);
    int nb;
    nb = (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 4;
    for (int i = 0; i < nb; i++) mem[k][8'(a + 24'(i))] = d[8*i +: 8];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    check("mem_enable", mem_enable, m_busy && cyc == m_t0 + 1);
    check("mem_addr", mem_addr, m_busy ? m_addr : 24'h0);
    check("mem_we", mem_we, m_busy && m_we);
    check("mem_data_in", mem_data_in, m_busy ? m_wdata : 32'h0);
    check("mem_instr_mode", mem_instr_mode, m_busy ? m_mode : 2'b00);
    check("if_ack", if_ack, m_busy && cyc == m_done_cyc && !m_is_d);
    check("d_ack", d_ack, m_busy && cyc == m_done_cyc && m_is_d);
    if (if_ack || d_ack) check("err", err, m_err);
    check("if_rdata", if_rdata, exp_if);
    check("d_rdata", d_rdata, exp_d);
  endtask

  task automatic model_update();
    logic [31:0] val;
    if (!rst_n) begin
      if (m_busy && m_we && m_done_cyc < 0 && cyc >= m_t0 + 1) mwrite(1, m_addr, m_mode, m_wdata);
      m_busy   = 0;
      m_last_d = 0;
      exp_if   = '0;
      exp_d    = '0;
    end else if (!m_busy) begin
      if (if_req || d_req) begin
        m_is_d     = d_req && (!if_req || !m_last_d);
        m_addr     = m_is_d ? d_addr : if_addr;
        m_we       = m_is_d && d_we;
        m_mode     = m_is_d ? d_mode : 2'b00;
        m_wdata    = m_is_d ? d_wdata : 32'h0;
        m_busy     = 1;
        m_t0       = cyc;
        m_done_cyc = -1;
      end
    end else if (m_done_cyc < 0) begin
      if (cyc >= m_t0 + 2 && (mem_op_r || cyc == m_t0 + 1 + TIMEOUT)) begin
        m_done_cyc = cyc + 1;
        m_err      = !mem_op_r;
        val        = (mem_op_r && !m_we) ? mread(1, m_addr, m_mode) : 32'h0;
        if (m_we) mwrite(1, m_addr, m_mode, m_wdata);
        if (m_is_d) exp_d = val;
        else        exp_if = val;
      end
    end else if (cyc == m_done_cyc) begin
      m_busy   = 0;
      m_last_d = m_is_d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    if (if_ack) acks.push_back('{cyc, 1'b0, if_rdata, err});
    if (d_ack)  acks.push_back('{cyc, 1'b1, d_rdata, err});
    if (mem_enable) begin
      en_cyc  = cyc;
      en_mode = mem_instr_mode;
    end

    rst_n   = !rst_cmd;
    rst_cmd = 0;
    if (!rst_n) begin
      f_pend = 0;
      d_pend = 0;
    end else begin
      if (f_auto && !f_pend && !f_gap && (f_cont || $urandom_range(0, 2) == 0)) begin
        f_pend = 1;
        f_a    = 24'($urandom);
      end
      if (d_auto && !d_pend && !d_gap && (d_cont || $urandom_range(0, 2) == 0)) begin
        d_pend = 1;
        d_a    = 24'($urandom);
        d_w    = 1'($urandom);
        d_m    = 2'($urandom_range(0, 2));
        d_wd   = $urandom;
      end
    end
    f_gap   = 0;
    d_gap   = 0;
    if_req  = f_pend;
    if_addr = f_a;
    d_req   = d_pend;
    d_we    = d_w;
    d_mode  = d_m;
    d_addr  = d_a;
    d_wdata = d_wd;
    if (if_ack) begin f_pend = 0; f_gap = 1; end
    if (d_ack)  begin d_pend = 0; d_gap = 1; end

    if (mem_enable) begin
      if (mem_we) mwrite(0, mem_addr, mem_instr_mode, mem_data_in);
      stub_rd   = mread(0, mem_addr, mem_instr_mode);
      stub_pend = (stub_mode != 2);
      stub_resp = cyc + ((stub_mode == 1) ? $urandom_range(1, TIMEOUT + 3) : 5);
    end
    mem_op_r     = 1'b0;
    mem_data_out = $urandom;
    if (stub_pend && cyc == stub_resp) begin
      mem_op_r     = 1'b1;
      mem_data_out = stub_rd;
      stub_pend    = 0;
    end else if (!stub_pend && spur_en && $urandom_range(0, 5) == 0) begin
      mem_op_r = 1'b1;
    end

    model_update();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    while ((m_busy || f_pend || d_pend) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle cyc=%0d got=busy expected=idle within 100 cycles", cyc);
    end
  endtask

  task automatic do_fetch(input logic [23:0] a, output int c0);
    f_a    = a;
    f_pend = 1;
    c0     = cyc + 1;
    acks.delete();
    wait_idle();
  endtask

  task automatic do_data(input logic we, input logic [1:0] m, input logic [23:0] a,
                         input logic [31:0] wd, output int c0);
    d_w    = we;
    d_m    = m;
    d_a    = a;
    d_wd   = wd;
    d_pend = 1;
    c0     = cyc + 1;
    acks.delete();
    wait_idle();
  endtask

  task automatic chk_ack(string nm, bit is_d, logic [31:0] rd, logic e);
    check({nm, "_ackcnt"}, acks.size(), 1);
    if (acks.size() > 0) begin
      check({nm, "_owner"}, acks[0].is_d, is_d);
      check({nm, "_rdata"}, acks[0].rdata, rd);
      check({nm, "_err"}, acks[0].err, e);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_mode = '0; d_addr = '0; d_wdata = '0;
    mem_op_r = 0; mem_data_out = '0;
    f_pend = 0; f_gap = 0; f_auto = 0; f_cont = 0; f_a = '0;
    d_pend = 0; d_gap = 0; d_auto = 0; d_cont = 0;
    d_w = 0; d_m = '0; d_a = '0; d_wd = '0;
    rst_cmd = 0; stub_mode = 0; spur_en = 0; stub_pend = 0; stub_resp = 0; stub_rd = '0;
    m_busy = 0; m_is_d = 0; m_last_d = 0; m_we = 0; m_err = 0;
    m_t0 = 0; m_done_cyc = -1; m_addr = '0; m_mode = '0; m_wdata = '0;
    exp_if = '0; exp_d = '0; en_cyc = 0; en_mode = '0;
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 8'(i * 37 + 5);
      mem[1][i] = 8'(i * 37 + 5);
    end
    for (int k = 0; k < 2; k++) begin
      mem[k][0] = 8'h13; mem[k][1] = 8'h91; mem[k][2] = 8'h31; mem[k][3] = 8'h00;
      mem[k][8'h11] = 8'hBB;
    end
    repeat (2) @(posedge clk);

    // reset state
    step();
    check("rst_mem_enable", mem_enable, 1'b0);
    check("rst_mem_addr", mem_addr, 24'h0);
    check("rst_if_ack", if_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);

    // fetch only, 4-cycle controller
    do_fetch(24'h000000, c0);
    chk_ack("fetch", 1'b0, 32'h00319113, 1'b0);
    check("fetch_enable_cycle", en_cyc - c0, 1);
    if (acks.size() > 0) check("fetch_ack_cycle", acks[0].cyc - c0, 7);

    // byte load
    do_data(1'b0, 2'b01, 24'h000011, 32'h0, c0);
    chk_ack("byte_load", 1'b1, 32'h000000BB, 1'b0);
    check("byte_mode", en_mode, 2'b01);

    // store word, then load it back
    do_data(1'b1, 2'b00, 24'h000010, 32'hAABBCCDD, c0);
    chk_ack("store", 1'b1, 32'h0, 1'b0);
    do_data(1'b0, 2'b00, 24'h000010, 32'h0, c0);
    chk_ack("load", 1'b1, 32'hAABBCCDD, 1'b0);

    // timeout, then a normal transaction
    stub_mode = 2;
    do_fetch(24'h000004, c0);
    chk_ack("timeout", 1'b0, 32'h0, 1'b1);
    if (acks.size() > 0) check("timeout_ack_cycle", acks[0].cyc - c0, TIMEOUT + 2);
    stub_mode = 0;
    do_fetch(24'h000000, c0);
    chk_ack("after_timeout", 1'b0, 32'h00319113, 1'b0);

    // reset while waiting on the controller
    f_a = 24'h000000; f_pend = 1;
    acks.delete();
    repeat (3) step();
    rst_cmd = 1;
    step();
    step();
    check("wrst_mem_enable", mem_enable, 1'b0);
    check("wrst_mem_addr", mem_addr, 24'h0);
    check("wrst_if_ack", if_ack, 1'b0);
    check("wrst_if_rdata", if_rdata, 32'h0);
    check("wrst_err", err, 1'b0);
    repeat (8) step();
    check("wrst_no_ack", acks.size(), 0);
    do_fetch(24'h000000, c0);
    chk_ack("wrst_recover", 1'b0, 32'h00319113, 1'b0);

    // simultaneous requests from reset, then both held continuously
    rst_cmd = 1;
    repeat (2) step();
    f_a = 24'h000020; d_a = 24'h000030; d_w = 0; d_m = 2'b00; d_wd = '0;
    f_pend = 1; d_pend = 1;
    f_auto = 1; d_auto = 1; f_cont = 1; d_cont = 1;
    acks.delete();
    for (int i = 0; i < 300 && acks.size() < 4; i++) step();
    if (acks.size() < 4) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tie_wait cyc=%0d got=%0d acks expected=4", cyc, acks.size());
    end
    f_auto = 0; d_auto = 0; f_cont = 0; d_cont = 0;
    for (int i = 0; i < 4 && i < acks.size(); i++) check("tie_order", acks[i].is_d, (i % 2) == 0);
    wait_idle();

    // randomized traffic under three controller behaviours
    f_auto = 1; d_auto = 1;
    for (int seg = 0; seg < 3; seg++) begin
      stub_mode = (seg == 0) ? 0 : 1;
      spur_en   = (seg == 2);
      repeat (600) step();
    end
    f_auto = 0; d_auto = 0; spur_en = 0;
    wait_idle();
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT, default 15: the maximum number of WAIT cycles before a transaction is aborted.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  instruction-fetch request, held until if_ack
- if_addr  in  24  fetch byte address
- if_ack  out  1  one-cycle fetch completion
- if_rdata  out  32  fetch data, valid with if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  data write enable
- d_mode  in  2  access size: 00 = word, 01 = byte, 10 = half
- d_addr  in  24  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle data completion
- d_rdata  out  32  load data, valid with d_ack
- err  out  1  timeout flag, valid only with an ack
- mem_addr  out  24  memory controller address
- mem_we  out  1  memory controller write enable
- mem_data_in  out  32  memory controller write data
- mem_enable  out  1  memory controller start pulse
- mem_instr_mode  out  2  memory controller access size
- mem_data_out  in  32  memory controller read data
- mem_op_r  in  1  memory controller data-ready pulse

Function
REQ-003 The block SHALL implement a four-state FSM with states IDLE, ISSUE, WAIT and DONE.
REQ-004 In IDLE, when any request is high, the block SHALL latch the winner's addr, we, mode and wdata, record the owner, and go to ISSUE. When no request is high, it SHALL stay in IDLE.
REQ-005 Arbitration SHALL grant the single pending requester. When both requests are high, it SHALL grant the requester not granted last (round-robin). last_grant SHALL update in DONE.
REQ-006 Fetch transactions SHALL be driven as mem_we=0 and mem_instr_mode=00.
REQ-007 In ISSUE, mem_enable SHALL be 1 for exactly one cycle, the timeout counter SHALL clear to 0, and the FSM SHALL go to WAIT. mem_enable SHALL be 0 in all other states.
REQ-008 mem_addr, mem_we, mem_data_in and mem_instr_mode SHALL be driven from the latched registers and held stable from ISSUE through DONE. In IDLE they SHALL be 0.
REQ-009 In WAIT, the counter SHALL increment each cycle. On mem_op_r=1, the block SHALL capture mem_data_out (reads) or 0 (writes) into the owner's rdata register and go to DONE.
REQ-010 In WAIT, if the counter reaches TIMEOUT with mem_op_r=0, the block SHALL set err=1, set the owner's rdata to 0, and go to DONE. If mem_op_r=1 occurs in that same cycle, the op_r capture SHALL take priority.
REQ-011 In DONE, only the owner's ack SHALL be 1, for exactly one cycle, with rdata and err valid; the FSM SHALL then return to IDLE. if_rdata and d_rdata SHALL hold their values until that port's next completion.
REQ-012 Requesters SHALL drop req in the cycle after their ack. A req still high in IDLE SHALL be treated as a new request.
REQ-013 Requests arriving during ISSUE, WAIT or DONE SHALL be ignored until IDLE. A mem_op_r outside WAIT SHALL be ignored.
REQ-014 Timing with the 4-cycle memory controller: for a req first high in IDLE cycle 0, mem_enable SHALL be high in cycle 1, mem_op_r arrives in cycle 6, and ack SHALL be high in cycle 7.

Reset
REQ-015 When rst_n=0 at a posedge, the block SHALL set: state IDLE, all acks, err and mem_enable to 0, all mem_* outputs to 0, rdata to 0, counter to 0, last_grant to fetch (so data wins the first tie).
REQ-016 Reset mid-transaction SHALL abandon the transaction without an ack. A mem_op_r arriving after reset SHALL be ignored.

Verification
REQ-017 Fetch only: if_req=1, if_addr=0x000000, memory holding 0x00319113 -> mem_enable in cycle 1, if_ack in cycle 7, if_rdata=0x00319113, err=0.
REQ-018 Store word then load: d_we=1, d_mode=00, d_addr=0x10, d_wdata=0xAABBCCDD -> d_ack with d_rdata=0; then a load of 0x10 -> d_rdata=0xAABBCCDD.
REQ-019 Tie: if_req and d_req asserted together from reset -> data granted first, fetch second. With both held continuously, grants alternate D, F, D, F.
REQ-020 Timeout: memory stub never asserts mem_op_r -> ack after TIMEOUT WAIT cycles with err=1 and rdata=0; the next transaction completes with err=0.
REQ-021 Byte mode: d_mode=01, load of 0x11 where mem[0x11]=0xBB -> mem_instr_mode=01, d_rdata=0x000000BB.
REQ-022 Reset in WAIT: rst_n=0 for one cycle -> no ack, all outputs 0, the late mem_op_r is ignored, and a subsequent fetch completes normally.
